// File: rtl/psum_writeback_scheduler.sv
// Row write-back sequencer: snapshots the PE-grid psums on capture, then
// streams unmasked lanes to memory as low/high 16-bit halves.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   capture          snapshot request (accepted only while idle)
//   capture_row      output row index of this snapshot
//   lane_mask        1 = write lane i
//   psum_vec         lane i at bits [i*PSUM_W +: PSUM_W]
//   result_base      base address of the result region
//   mem_wr_en        write request
//   mem_wr_addr      write address
//   mem_wr_data      write data
//   mem_wr_ready     memory accepts the write this cycle
//   busy             snapshot in progress
//   row_done         one-cycle pulse once the row is written
//   overflow         sticky: a capture arrived while busy
//   clear_overflow   clears overflow (a same-cycle drop wins)
module psum_writeback_scheduler #(
  parameter int NUM_LANES = 14,
  parameter int PSUM_W    = 32,
  parameter int MEM_W     = 16,
  parameter int ADDR_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        capture,
  input  logic [7:0]                  capture_row,
  input  logic [NUM_LANES-1:0]        lane_mask,
  input  logic [NUM_LANES*PSUM_W-1:0] psum_vec,
  input  logic [ADDR_W-1:0]           result_base,
  output logic                        mem_wr_en,
  output logic [ADDR_W-1:0]           mem_wr_addr,
  output logic [MEM_W-1:0]            mem_wr_data,
  input  logic                        mem_wr_ready,
  output logic                        busy,
  output logic                        row_done,
  output logic                        overflow,
  input  logic                        clear_overflow
);

  localparam int LANE_W = $clog2(NUM_LANES);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(2 * NUM_LANES);

  typedef enum logic [1:0] {
    IDLE,
    WRITE_LO,
    WRITE_HI,
    ROW_DONE
  } state_t;

  state_t state_q, state_d;

  logic [LANE_W-1:0]    lane_q, lane_d;
  logic [PSUM_W-1:0]    snap_psum [NUM_LANES];
  logic [NUM_LANES-1:0] snap_mask;
  logic [7:0]           snap_row;
  logic [ADDR_W-1:0]    snap_base;

  logic              load;
  logic              xfer;
  logic              is_hi;
  logic              first_found;
  logic [LANE_W-1:0] first_lane;
  logic              next_found;
  logic [LANE_W-1:0] next_lane;
  logic [PSUM_W-1:0] lane_psum;
  logic [ADDR_W-1:0] addr_raw;

  assign busy      = (state_q != IDLE);
  assign row_done  = (state_q == ROW_DONE);
  assign is_hi     = (state_q == WRITE_HI);
  assign mem_wr_en = (state_q == WRITE_LO) || is_hi;
  assign xfer      = mem_wr_en && mem_wr_ready;

  // Lowest set bit of the live mask picks the first lane.
  always_comb begin
    first_found = 1'b0;
    first_lane  = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (lane_mask[i]) begin
        first_found = 1'b1;
        first_lane  = LANE_W'(i);
      end
    end
  end

  // Lowest snapshot mask bit strictly above the current lane.
  always_comb begin
    next_found = 1'b0;
    next_lane  = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (snap_mask[i] && (LANE_W'(i) > lane_q)) begin
        next_found = 1'b1;
        next_lane  = LANE_W'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (capture) begin
          load    = 1'b1;
          lane_d  = first_lane;
          state_d = first_found ? WRITE_LO : ROW_DONE;
        end
      end
      WRITE_LO: begin
        if (xfer) begin
          state_d = WRITE_HI;
        end
      end
      WRITE_HI: begin
        if (xfer) begin
          if (next_found) begin
            lane_d  = next_lane;
            state_d = WRITE_LO;
          end else begin
            state_d = ROW_DONE;
          end
        end
      end
      ROW_DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lane_q    <= '0;
      snap_mask <= '0;
      snap_row  <= '0;
      snap_base <= '0;
      overflow  <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
        snap_psum[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      if (load) begin
        snap_mask <= lane_mask;
        snap_row  <= capture_row;
        snap_base <= result_base;
        for (int i = 0; i < NUM_LANES; i++) begin
          snap_psum[i] <= psum_vec[i*PSUM_W +: PSUM_W];
        end
      end
      if (capture && busy) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  // Each row owns 2*NUM_LANES consecutive words; sum wraps at ADDR_W.
  assign lane_psum = snap_psum[lane_q];
  assign addr_raw  = snap_base
                   + ADDR_W'(snap_row) * ROW_STRIDE
                   + ADDR_W'({lane_q, is_hi});

  // Bus is driven to zero whenever no write is requested.
  assign mem_wr_addr = mem_wr_en ? addr_raw : '0;
  assign mem_wr_data = !mem_wr_en ? '0
                     : is_hi ? lane_psum[PSUM_W-1:MEM_W]
                     : lane_psum[MEM_W-1:0];

endmodule

// File: tb/tb_psum_writeback_scheduler.sv
// Directed bench for psum_writeback_scheduler.
// Inputs driven and outputs sampled on the falling edge.
module tb_psum_writeback_scheduler;

  localparam int NL = 14;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          capture;
  logic [7:0]    capture_row;
  logic [NL-1:0] lane_mask;
  logic [NL*32-1:0] psum_vec;
  logic [15:0]   result_base;
  logic          mem_wr_en;
  logic [15:0]   mem_wr_addr;
  logic [15:0]   mem_wr_data;
  logic          mem_wr_ready;
  logic          busy;
  logic          row_done;
  logic          overflow;
  logic          clear_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] psum_arr [NL];

  always #5 clk = ~clk;

  psum_writeback_scheduler dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .capture        (capture),
    .capture_row    (capture_row),
    .lane_mask      (lane_mask),
    .psum_vec       (psum_vec),
    .result_base    (result_base),
    .mem_wr_en      (mem_wr_en),
    .mem_wr_addr    (mem_wr_addr),
    .mem_wr_data    (mem_wr_data),
    .mem_wr_ready   (mem_wr_ready),
    .busy           (busy),
    .row_done       (row_done),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_vec();
    for (int i = 0; i < NL; i++) begin
      psum_vec[i*32 +: 32] = psum_arr[i];
    end
  endtask

  // Called at a falling edge; returns at a falling edge.
  task automatic run_row(input logic [NL-1:0] mask,
                         input logic [7:0]    row,
                         input logic [15:0]   base,
                         input bit            toggle,
                         input int            drop_cyc,
                         input int            clr_cyc,
                         input int            exp_done,
                         input string         nm);
    logic [15:0] ea [$];
    logic [15:0] ed [$];
    logic [15:0] a;
    logic [15:0] pa, pd;
    logic        pen, prdy;
    int k, xfers, en_cyc, done_cnt, done_cyc, limit;
    k = 0;
    for (int i = 0; i < NL; i++) begin
      if (mask[i]) begin
        k++;
        for (int h = 0; h < 2; h++) begin
          // row stride is 2*NL words
          a = base + 16'(row) * 16'd28 + 16'(2 * i + h);
          ea.push_back(a);
          ed.push_back(h == 1 ? psum_arr[i][31:16]
                              : psum_arr[i][15:0]);
        end
      end
    end
    xfers = 0; en_cyc = 0; done_cnt = 0; done_cyc = 0;
    pen = 1'b0; prdy = 1'b0; pa = '0; pd = '0;
    limit = 4 * k + 10;
    capture      = 1'b1;
    capture_row  = row;
    lane_mask    = mask;
    result_base  = base;
    mem_wr_ready = 1'b1;
    load_vec();
    @(negedge clk);
    for (int c = 1; c <= limit; c++) begin
      capture        = (c == drop_cyc);
      clear_overflow = (c == clr_cyc);
      if (c == drop_cyc) begin
        capture_row = 8'hEE;
        result_base = 16'h5555;
      end
      if (c == 1) begin
        psum_vec  = ~psum_vec;
        lane_mask = ~mask;
      end
      mem_wr_ready = toggle ? (c % 2 == 1) : 1'b1;
      if (done_cnt > 0 && c == done_cyc + 1) begin
        check({nm, "_busy_after"}, 32'(busy), 32'd0);
        check({nm, "_done_width"}, 32'(row_done), 32'd0);
        break;
      end
      if (mem_wr_en) begin
        en_cyc++;
        if (pen && !prdy) begin
          check({nm, "_hold_addr"}, 32'(mem_wr_addr), 32'(pa));
          check({nm, "_hold_data"}, 32'(mem_wr_data), 32'(pd));
        end
        if (mem_wr_ready) begin
          xfers++;
          if (ea.size() == 0) begin
            check({nm, "_extra_write"}, 32'(mem_wr_addr), 32'hFFFF_FFFF);
          end else begin
            check({nm, "_addr"}, 32'(mem_wr_addr), 32'(ea.pop_front()));
            check({nm, "_data"}, 32'(mem_wr_data), 32'(ed.pop_front()));
          end
        end
      end
      if (row_done) begin
        done_cnt++;
        done_cyc = c;
        check({nm, "_busy_at_done"}, 32'(busy), 32'd1);
      end
      pen = mem_wr_en; prdy = mem_wr_ready;
      pa = mem_wr_addr; pd = mem_wr_data;
      @(negedge clk);
    end
    capture        = 1'b0;
    clear_overflow = 1'b0;
    check({nm, "_done_count"}, 32'(done_cnt), 32'd1);
    check({nm, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
    check({nm, "_xfers"}, 32'(xfers), 32'(2 * k));
    if (!toggle) begin
      check({nm, "_en_cycles"}, 32'(en_cyc), 32'(2 * k));
    end
  endtask

  initial begin
    int nw, bad;
    rst_n          = 1'b0;
    capture        = 1'b1;
    capture_row    = 8'h01;
    lane_mask      = '1;
    psum_vec       = '1;
    result_base    = 16'h1234;
    mem_wr_ready   = 1'b1;
    clear_overflow = 1'b0;
    for (int i = 0; i < NL; i++) psum_arr[i] = '0;

    @(negedge clk);
    @(negedge clk);
    check("rst_en",       32'(mem_wr_en),   32'd0);
    check("rst_addr",     32'(mem_wr_addr), 32'd0);
    check("rst_data",     32'(mem_wr_data), 32'd0);
    check("rst_busy",     32'(busy),        32'd0);
    check("rst_row_done", 32'(row_done),    32'd0);
    check("rst_overflow", 32'(overflow),    32'd0);
    rst_n   = 1'b1;
    capture = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy),      32'd0);
    check("idle_en",   32'(mem_wr_en), 32'd0);

    for (int i = 0; i < NL; i++)
      psum_arr[i] = 32'h0001_0000 * i + i;
    run_row(14'h3FFF, 8'd0, 16'h2000, 1'b0, -1, -1, 29, "full");
    check("full_no_ovf", 32'(overflow), 32'd0);

    for (int i = 0; i < NL; i++)
      psum_arr[i] = 32'hB000_C000 + 32'h0001_0001 * i;
    run_row(14'b10_0000_0000_0101, 8'd3, 16'h2000, 1'b1,
            -1, -1, 12, "sparse");

    run_row(14'h0000, 8'd5, 16'h2000, 1'b0, -1, -1, 1, "empty");

    run_row(14'h0003, 8'd1, 16'h1000, 1'b0, 2, -1, 5, "ovf_a");
    check("ovf_set", 32'(overflow), 32'd1);
    run_row(14'h0003, 8'd1, 16'h1000, 1'b0, 2, 2, 5, "ovf_b");
    check("ovf_set_wins", 32'(overflow), 32'd1);
    clear_overflow = 1'b1;
    @(negedge clk);
    clear_overflow = 1'b0;
    check("ovf_clear", 32'(overflow), 32'd0);

    run_row(14'h0003, 8'd0, 16'hFFFE, 1'b0, -1, -1, 5, "wrap");

    capture      = 1'b1;
    capture_row  = 8'd0;
    lane_mask    = 14'h0003;
    result_base  = 16'hFFFE;
    mem_wr_ready = 1'b1;
    load_vec();
    @(negedge clk);
    capture = 1'b0;
    nw = 0;
    for (int c = 1; c <= 3; c++) begin
      if (mem_wr_en && mem_wr_ready) nw++;
      if (c < 3) @(negedge clk);
    end
    check("mid_writes", 32'(nw), 32'd3);
    rst_n = 1'b0;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (mem_wr_en || row_done || busy) bad++;
      if (c == 1) rst_n = 1'b1;
    end
    check("mid_rst_quiet", 32'(bad), 32'd0);

    run_row(14'h0001, 8'd2, 16'h3000, 1'b0, -1, -1, 3, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
